// File: rtl/alu_issue_seq_if.sv
// Instruction handshake, ALU drive/result bus and debug read port of the issue sequencer.
// The master side is the upstream/ALU environment; the slave side is the sequencer itself.
interface alu_issue_seq_if #(
  parameter int DATA_W = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [7:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              done;
  logic              illegal;
  logic [1:0]        dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output instr_valid, instr, alu_res, dbg_sel,
    input  instr_ready, alu_op, alu_a, alu_b, done, illegal, dbg_data
  );

  modport slave (
    input  instr_valid, instr, alu_res, dbg_sel,
    output instr_ready, alu_op, alu_a, alu_b, done, illegal, dbg_data
  );
endinterface

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer in front of the 8-bit ALU: one instruction per
// IDLE -> EXEC -> WB pass, operands from a small register file, result written back.
module alu_issue_seq #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_issue_seq_if.slave bus
);
  localparam int IDX_W = $clog2(REG_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  localparam logic [2:0] OP_LOADI = 3'b001;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];
  logic [7:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [IDX_W-1:0]  rd_q, rd_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              live_q, live_d;   // low only until the first edge after reset release

  logic [2:0]        opcode;
  logic [IDX_W-1:0]  ra, rb;
  logic              accept;

  assign opcode = bus.instr[15:13];
  assign ra     = bus.instr[10:9];
  assign rb     = bus.instr[8:7];

  assign bus.instr_ready = (state_q == IDLE) && live_q;
  assign accept          = bus.instr_valid && bus.instr_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    regs_d    = regs_q;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    res_d     = res_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    live_d    = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (opcode[2:1] == 2'b11) begin
            // Reserved opcodes are dropped without touching the ALU bus or registers.
            illegal_d = 1'b1;
          end else begin
            rd_d     = bus.instr[12:11];
            alu_op_d = {5'b0, opcode};
            if (opcode == OP_LOADI) begin
              alu_a_d = DATA_W'(bus.instr[7:0]);
              alu_b_d = '0;
            end else begin
              alu_a_d = regs_q[ra];
              alu_b_d = regs_q[rb];
            end
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        res_d   = bus.alu_res;
        done_d  = 1'b1;
        state_d = WB;
      end
      WB: begin
        regs_d[rd_q] = res_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      // NOTE: the register file is tiny and architecturally visible, so it is reset like any flop.
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      res_q     <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      res_q     <= res_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      live_q    <= live_d;
    end
  end

  assign bus.alu_op   = alu_op_q;
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.done     = done_q;
  assign bus.illegal  = illegal_q;
  assign bus.dbg_data = regs_q[bus.dbg_sel];
endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: directed scenarios plus random instructions
// compared against a register-file model and a behavioural ALU.
module tb_alu_issue_seq;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_seq_if #(.DATA_W(DATA_W)) bus ();

  alu_issue_seq #(.DATA_W(DATA_W), .REG_N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Behavioural ALU sitting downstream of the sequencer.
  always_comb begin
    case (bus.alu_op)
      8'd0:    bus.alu_res = bus.alu_a;
      8'd1:    bus.alu_res = bus.alu_a;
      8'd2:    bus.alu_res = bus.alu_a + bus.alu_b;
      8'd3:    bus.alu_res = bus.alu_a & bus.alu_b;
      8'd4:    bus.alu_res = bus.alu_a - bus.alu_b;
      8'd5:    bus.alu_res = bus.alu_a | bus.alu_b;
      default: bus.alu_res = '0;
    endcase
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] mregs [4];
  logic [7:0] last_op, last_a, last_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] ra, input logic [1:0] rb);
    return {op, rd, ra, rb, 7'b0};
  endfunction

  function automatic logic [15:0] mk_i(input logic [1:0] rd, input logic [7:0] imm);
    return {3'b001, rd, 3'b000, imm};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) mregs[i] = 8'd0;
    last_op = 8'd0;
    last_a  = 8'd0;
    last_b  = 8'd0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      bus.dbg_sel = 2'(i);
      #1;
      check(tag, 32'(bus.dbg_data), 32'(mregs[i]));
    end
  endtask

  // Presents one instruction, waits for it to be accepted and follows it to completion.
  task automatic issue(input logic [15:0] ins);
    logic [2:0] op;
    logic [1:0] rd, ra, rb;
    logic [7:0] ea, eb, eres;
    int n;
    op = ins[15:13];
    rd = ins[12:11];
    ra = ins[10:9];
    rb = ins[8:7];
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    n = 0;
    while (!bus.instr_ready && n < 10) begin
      tick();
      n++;
    end
    check("accept_ready", 32'(bus.instr_ready), 32'd1);
    if (op >= 3'd6) begin
      tick();
      bus.instr_valid = 1'b0;
      bus.instr       = 16'($urandom);
      check("illegal_pulse", 32'(bus.illegal), 32'd1);
      check("illegal_no_done", 32'(bus.done), 32'd0);
      check("illegal_ready", 32'(bus.instr_ready), 32'd1);
      check("illegal_op_held", 32'(bus.alu_op), 32'(last_op));
      check("illegal_a_held", 32'(bus.alu_a), 32'(last_a));
      check("illegal_b_held", 32'(bus.alu_b), 32'(last_b));
      tick();
      check("illegal_one_cycle", 32'(bus.illegal), 32'd0);
    end else begin
      ea = (op == 3'd1) ? ins[7:0] : mregs[ra];
      eb = (op == 3'd1) ? 8'd0 : mregs[rb];
      case (op)
        3'd2:    eres = 8'((int'(ea) + int'(eb)) % 256);
        3'd3:    eres = ea & eb;
        3'd4:    eres = 8'((int'(ea) - int'(eb) + 256) % 256);
        3'd5:    eres = ea | eb;
        default: eres = ea;
      endcase
      tick();
      bus.instr_valid = 1'b0;
      bus.instr       = 16'($urandom);
      bus.dbg_sel     = rd;
      check("exec_ready", 32'(bus.instr_ready), 32'd0);
      check("exec_op", 32'(bus.alu_op), 32'(op));
      check("exec_a", 32'(bus.alu_a), 32'(ea));
      check("exec_b", 32'(bus.alu_b), 32'(eb));
      check("exec_no_done", 32'(bus.done), 32'd0);
      tick();
      check("wb_done", 32'(bus.done), 32'd1);
      check("wb_ready", 32'(bus.instr_ready), 32'd0);
      check("wb_old_value", 32'(bus.dbg_data), 32'(mregs[rd]));
      tick();
      check("post_done_low", 32'(bus.done), 32'd0);
      check("post_ready", 32'(bus.instr_ready), 32'd1);
      check("post_new_value", 32'(bus.dbg_data), 32'(eres));
      mregs[rd] = eres;
      last_op   = {5'b0, op};
      last_a    = ea;
      last_b    = eb;
    end
  endtask

  initial begin
    int acc_cyc [3];
    int accepts;
    int n;

    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.dbg_sel     = '0;
    clear_model();

    // Reset state.
    #12;
    check("rst_ready", 32'(bus.instr_ready), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_op", 32'(bus.alu_op), 32'd0);
    check("rst_a", 32'(bus.alu_a), 32'd0);
    check("rst_b", 32'(bus.alu_b), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("release_ready", 32'(bus.instr_ready), 32'd1);
    check_regs("rst_regs");

    // Wrap-around add.
    issue(mk_i(2'd1, 8'd200));
    issue(mk_i(2'd2, 8'd100));
    issue(mk(3'd2, 2'd3, 2'd1, 2'd2));
    check("add_wrap", 32'(mregs[3]), 32'd44);

    // SUB underflow, then logic ops and MOV.
    issue(mk_i(2'd1, 8'd5));
    issue(mk_i(2'd2, 8'd7));
    issue(mk(3'd4, 2'd0, 2'd1, 2'd2));
    issue(mk_i(2'd1, 8'hF0));
    issue(mk_i(2'd2, 8'h3C));
    issue(mk(3'd3, 2'd3, 2'd1, 2'd2));
    issue(mk(3'd5, 2'd3, 2'd1, 2'd2));
    issue(mk(3'd0, 2'd3, 2'd1, 2'd0));
    check_regs("logic_regs");

    // Reserved opcodes.
    issue(mk(3'd6, 2'd1, 2'd2, 2'd3));
    issue(mk(3'd7, 2'd2, 2'd0, 2'd1));
    check_regs("reserved_regs");

    // Reset during WB of an ADD into r2 aborts the writeback.
    issue(mk_i(2'd2, 8'd9));
    bus.instr       = mk(3'd2, 2'd2, 2'd1, 2'd2);
    bus.instr_valid = 1'b1;
    bus.dbg_sel     = 2'd2;
    check("abort_ready", 32'(bus.instr_ready), 32'd1);
    tick();
    bus.instr_valid = 1'b0;
    tick();
    check("abort_in_wb", 32'(bus.done), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_ready_low", 32'(bus.instr_ready), 32'd0);
    check("abort_r2", 32'(bus.dbg_data), 32'd0);
    clear_model();
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_release_ready", 32'(bus.instr_ready), 32'd1);
    check_regs("abort_regs");

    // Back-to-back ADD r1=r1+r1 with instr_valid held high.
    issue(mk_i(2'd1, 8'd3));
    bus.dbg_sel     = 2'd1;
    bus.instr       = mk(3'd2, 2'd1, 2'd1, 2'd1);
    bus.instr_valid = 1'b1;
    accepts = 0;
    n = 0;
    while (accepts < 3 && n < 20) begin
      if (bus.instr_ready) begin
        if (accepts > 0) check("b2b_chain", 32'(bus.dbg_data), 32'(3 << accepts));
        acc_cyc[accepts] = cyc;
        accepts++;
      end
      tick();
      n++;
    end
    bus.instr_valid = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd3);
    if (accepts == 3) begin
      check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    end
    tick();
    tick();
    mregs[1] = 8'd24;
    last_op  = 8'd2;
    last_a   = 8'd12;
    last_b   = 8'd12;
    check_regs("b2b_regs");

    // Random instructions, reserved opcodes included.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == 3'd1) issue(mk_i(2'($urandom), 8'($urandom)));
      else            issue(mk(op, 2'($urandom), 2'($urandom), 2'($urandom)));
    end
    check_regs("rand_regs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
